// File: rtl/seq_gate_fsm_if.sv
// seq_gate_fsm_if: start/confirm inputs and status outputs of the sequence gate
interface seq_gate_fsm_if #(parameter int CNT_W = 8);
  logic a;
  logic b;
  logic y0;
  logic z;
  logic timeout_err;
  logic busy;
  logic [CNT_W-1:0] done_count;
  modport master (output a, b, input y0, z, timeout_err, busy, done_count);
  modport slave (input a, b, output y0, z, timeout_err, busy, done_count);
endinterface

// File: rtl/seq_gate_fsm.sv
// seq_gate_fsm: start/confirm handshake with timed y0 hold, completion pulse, timeout error and done counter
module seq_gate_fsm #(
  parameter int TIMEOUT = 8,
  parameter int HOLD_CYCLES = 1,
  parameter int AUTO_REARM = 0,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  seq_gate_fsm_if.slave bus
);
  localparam int MX = TIMEOUT > HOLD_CYCLES ? TIMEOUT : HOLD_CYCLES;
  localparam int TW = $clog2(MX + 1);
  localparam logic [TW-1:0] TO_L = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] HD_L = TW'(HOLD_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, WAIT_B, HOLD, FIN, ERR} state_t;
  state_t r_state, w_nxt;
  logic w_inc;
  logic [TW-1:0] r_timer;
  logic [CNT_W-1:0] r_cnt;
  logic r_y0, r_z, r_err, r_busy;
  // next state; b beats the timeout in WAIT_B, stray encodings fall back to IDLE
  always_comb begin
    w_nxt = IDLE;
    w_inc = 1'b0;
    case (r_state)
      IDLE:   w_nxt = bus.a ? WAIT_B : IDLE;
      WAIT_B: begin
        w_nxt = bus.b ? HOLD : (TIMEOUT != 0 && r_timer == TO_L) ? ERR : WAIT_B;
        w_inc = 1'b1;
      end
      HOLD:   begin
        w_nxt = r_timer == HD_L ? FIN : HOLD;
        w_inc = 1'b1;
      end
      FIN:    w_nxt = (AUTO_REARM != 0 && bus.a) ? WAIT_B : IDLE;
      ERR:    w_nxt = bus.a ? ERR : IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  // state, timer (cleared on any state change), saturating count and outputs registered from next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_cnt <= '0;
      r_y0 <= 1'b0;
      r_z <= 1'b0;
      r_err <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_timer <= (w_nxt != r_state) ? '0 : r_timer + TW'(w_inc);
      r_cnt <= (r_state == FIN && r_cnt != '1) ? r_cnt + CNT_W'(1) : r_cnt;
      r_y0 <= w_nxt == HOLD;
      r_z <= w_nxt == FIN;
      r_err <= w_nxt == ERR;
      r_busy <= w_nxt != IDLE;
    end
  end
  assign bus.y0 = r_y0;
  assign bus.z = r_z;
  assign bus.timeout_err = r_err;
  assign bus.busy = r_busy;
  assign bus.done_count = r_cnt;
endmodule

// File: tb/tb_seq_gate_fsm.sv
// tb_seq_gate_fsm: three parameterisations checked by vector table, directed sequences and a random run against a behavioural model
module tb_seq_gate_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  seq_gate_fsm_if #(.CNT_W(8)) if0 ();
  seq_gate_fsm_if #(.CNT_W(2)) if1 ();
  seq_gate_fsm_if #(.CNT_W(8)) if2 ();
  seq_gate_fsm #(.TIMEOUT(8), .HOLD_CYCLES(1), .AUTO_REARM(0), .CNT_W(8)) u0 (.clk(clk), .reset(reset), .bus(if0));
  seq_gate_fsm #(.TIMEOUT(4), .HOLD_CYCLES(1), .AUTO_REARM(1), .CNT_W(2)) u1 (.clk(clk), .reset(reset), .bus(if1));
  seq_gate_fsm #(.TIMEOUT(0), .HOLD_CYCLES(5), .AUTO_REARM(0), .CNT_W(8)) u2 (.clk(clk), .reset(reset), .bus(if2));
  int total = 0;
  int bad = 0;
  int p_to[3] = '{8, 4, 0};
  int p_hd[3] = '{1, 1, 5};
  int p_ar[3] = '{0, 1, 0};
  int p_max[3] = '{255, 3, 255};
  bit m_wait[3];
  bit m_fin[3];
  bit m_err[3];
  int m_age[3];
  int m_hold[3];
  int m_done[3];
  typedef struct {logic a; logic b; logic [3:0] o; logic [7:0] c;} vec_t;
  vec_t tbl[11];
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction
  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      m_wait[i] = 0; m_fin[i] = 0; m_err[i] = 0;
      m_age[i] = 0; m_hold[i] = 0; m_done[i] = 0;
    end
  endfunction
  function automatic void m_step(int i, bit a, bit b);
    if (m_wait[i]) begin
      if (b) begin
        m_wait[i] = 0;
        m_hold[i] = p_hd[i];
      end else begin
        m_age[i]++;
        if (p_to[i] != 0 && m_age[i] == p_to[i]) begin
          m_wait[i] = 0;
          m_err[i] = 1;
        end
      end
    end else if (m_hold[i] > 0) begin
      m_hold[i]--;
      if (m_hold[i] == 0) m_fin[i] = 1;
    end else if (m_fin[i]) begin
      m_fin[i] = 0;
      if (m_done[i] < p_max[i]) m_done[i]++;
      if (p_ar[i] != 0 && a) begin
        m_wait[i] = 1;
        m_age[i] = 0;
      end
    end else if (m_err[i]) begin
      if (!a) m_err[i] = 0;
    end else if (a) begin
      m_wait[i] = 1;
      m_age[i] = 0;
    end
  endfunction
  function automatic logic [3:0] m_outs(int i);
    logic hb;
    hb = m_hold[i] > 0;
    return {hb, m_fin[i], m_err[i], m_wait[i] | hb | m_fin[i] | m_err[i]};
  endfunction
  function automatic logic [3:0] outs(int i);
    return i == 0 ? {if0.y0, if0.z, if0.timeout_err, if0.busy} :
           i == 1 ? {if1.y0, if1.z, if1.timeout_err, if1.busy} :
                    {if2.y0, if2.z, if2.timeout_err, if2.busy};
  endfunction
  function automatic logic [7:0] cnt(int i);
    return i == 0 ? if0.done_count : i == 1 ? {6'b0, if1.done_count} : if2.done_count;
  endfunction
  task automatic tick(input logic [2:0] av, input logic [2:0] bv);
    if0.a = av[0]; if0.b = bv[0];
    if1.a = av[1]; if1.b = bv[1];
    if2.a = av[2]; if2.b = bv[2];
    @(posedge clk);
    for (int i = 0; i < 3; i++) m_step(i, av[i], bv[i]);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model%0d_outs", i), outs(i), m_outs(i));
      chk($sformatf("model%0d_cnt", i), cnt(i), m_done[i]);
    end
  endtask
  task automatic do_reset();
    if0.a = 0; if0.b = 0; if1.a = 0; if1.b = 0; if2.a = 0; if2.b = 0;
    @(posedge clk);
    #2 reset = 1'b1;
    m_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_outs", i), outs(i), 4'b0000);
      chk($sformatf("rst%0d_cnt", i), cnt(i), 0);
    end
    reset = 1'b0;
  endtask
  initial begin
    int last_z[3];
    int nz1;
    bit pend;
    if0.a = 0; if0.b = 0; if1.a = 0; if1.b = 0; if2.a = 0; if2.b = 0;
    m_reset();
    tbl[0]  = '{1'b1, 1'b0, 4'b0001, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 4'b0001, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 4'b0001, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 4'b1001, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 4'b0101, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 4'b0000, 8'd1};
    tbl[6]  = '{1'b1, 1'b1, 4'b0001, 8'd1};
    tbl[7]  = '{1'b0, 1'b0, 4'b0001, 8'd1};
    tbl[8]  = '{1'b0, 1'b1, 4'b1001, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 4'b0101, 8'd1};
    tbl[10] = '{1'b0, 1'b0, 4'b0000, 8'd2};
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("init%0d_outs", i), outs(i), 4'b0000);
      chk($sformatf("init%0d_cnt", i), cnt(i), 0);
    end
    reset = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tick({2'b00, tbl[k].a}, {2'b00, tbl[k].b});
      chk($sformatf("tbl%0d_outs", k), outs(0), tbl[k].o);
      chk($sformatf("tbl%0d_cnt", k), cnt(0), tbl[k].c);
    end
    tick(3'b010, 3'b000);
    chk("to_wait0", outs(1), 4'b0001);
    for (int k = 0; k < 3; k++) begin
      tick(3'b010, 3'b000);
      chk("to_wait", outs(1), 4'b0001);
    end
    tick(3'b010, 3'b000);
    chk("to_err", outs(1), 4'b0011);
    tick(3'b010, 3'b000);
    tick(3'b010, 3'b000);
    chk("to_err_held", outs(1), 4'b0011);
    tick(3'b000, 3'b000);
    chk("to_err_exit", outs(1), 4'b0000);
    chk("to_cnt", cnt(1), 0);
    tick(3'b010, 3'b000);
    tick(3'b010, 3'b000);
    tick(3'b010, 3'b000);
    tick(3'b010, 3'b010);
    chk("to_last_b", outs(1), 4'b1001);
    tick(3'b000, 3'b000);
    chk("to_last_fin", outs(1), 4'b0101);
    tick(3'b000, 3'b000);
    chk("to_last_cnt", cnt(1), 1);
    tick(3'b100, 3'b000);
    for (int k = 0; k < 100; k++) begin
      tick(3'b000, 3'b000);
      chk("nto_wait", outs(2), 4'b0001);
    end
    tick(3'b000, 3'b100);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold5_y0_%0d", k), outs(2), 4'b1001);
      tick(3'b000, 3'b000);
    end
    chk("hold5_fin", outs(2), 4'b0101);
    tick(3'b000, 3'b000);
    chk("hold5_idle", outs(2), 4'b0000);
    chk("hold5_cnt", cnt(2), 1);
    do_reset();
    last_z = '{-1, -1, -1};
    nz1 = 0;
    pend = 0;
    for (int n = 0; n < 24; n++) begin
      tick(3'b111, 3'b111);
      if (pend) begin
        chk($sformatf("sat_cnt_%0d", nz1), cnt(1), nz1 > 3 ? 3 : nz1);
        pend = 0;
      end
      if (outs(1)[2]) begin
        nz1++;
        pend = 1;
      end
      for (int i = 0; i < 3; i++) begin
        if (outs(i)[2]) begin
          if (last_z[i] >= 0) chk($sformatf("period%0d", i), n - last_z[i], i == 0 ? 4 : i == 1 ? 3 : 8);
          last_z[i] = n;
        end
      end
    end
    chk("sat_seen", nz1 >= 5, 1);
    for (int k = 0; k < 10; k++) tick(3'b000, 3'b000);
    tick(3'b001, 3'b000);
    tick(3'b000, 3'b001);
    chk("ar_hold", outs(0), 4'b1001);
    #2 reset = 1'b1;
    #1;
    chk("ar_y0_busy", outs(0), 4'b0000);
    chk("ar_cnt", cnt(0), 0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    tick(3'b001, 3'b000);
    chk("ar_restart_busy", outs(0), 4'b0001);
    tick(3'b000, 3'b001);
    chk("ar_restart_y0", outs(0), 4'b1001);
    for (int k = 0; k < 1500; k++)
      tick(3'($urandom), 3'($urandom) & 3'($urandom) & 3'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
